// File: rtl/weight_word_gen.sv
// weight_word_gen
//   Produces, in ascending numeric order, every 16-bit word whose population
//   count equals a requested weight. Words are handed out over a valid/ready
//   stream with a running ordinal.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   start      request a new sequence (honoured only in IDLE)
//   weight     number of ones per word, 0..16 (sampled with an accepted start)
//   out_ready  consumer accepts the presented word this cycle
//   out_valid  word/index are valid (high throughout EMIT)
//   word       current word of the sequence
//   index      ordinal of the current word, starting at 0
//   busy       high while in EMIT
//   done       one-cycle pulse after the last word transfers
//   err        one-cycle pulse when start arrives with weight > 16
module weight_word_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [4:0]  weight,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] word,
  output logic [13:0] index,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EMIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] word_q, word_d;
  logic [13:0] index_q, index_d;
  logic [4:0]  wt_q, wt_d;
  logic        err_q, err_d;
  logic        is_last;

  // Largest word of a given weight: the ones packed into the top bits.
  // Covers w=0 (0x0000) and w=16 (0xFFFF) without special cases.
  function automatic logic [15:0] final_word(input logic [4:0] w);
    return ~(16'hFFFF >> w);
  endfunction

  // Count of trailing zeros; 16 for a zero input.
  function automatic logic [4:0] ctz16(input logic [15:0] x);
    logic [4:0] n;
    n = 5'd16;
    for (int i = 15; i >= 0; i--) begin
      if (x[i]) n = 5'(i);
    end
    return n;
  endfunction

  // Next larger value with the same popcount (Gosper's hack). The divide by
  // the lowest set bit is replaced with a shift by its position. Callers
  // must only pass non-final, non-zero words so the ripple add stays in 16 bits.
  function automatic logic [15:0] gosper_next(input logic [15:0] x);
    logic [15:0] low;
    logic [15:0] ripple;
    logic [15:0] ones;
    logic [4:0]  tz;
    low    = x & (~x + 16'd1);
    ripple = x + low;
    tz     = ctz16(x);
    ones   = (ripple ^ x) >> (tz + 5'd2);
    return ripple | ones;
  endfunction

  assign is_last = (word_q == final_word(wt_q));

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    index_d = index_q;
    wt_d    = wt_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (weight > 5'd16) begin
            err_d = 1'b1;
          end else begin
            wt_d    = weight;
            word_d  = ~(16'hFFFF << weight);
            index_d = 14'd0;
            state_d = S_EMIT;
          end
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          // Successor is only formed for non-final words.
          if (is_last) begin
            state_d = S_DONE;
          end else begin
            word_d  = gosper_next(word_q);
            index_d = index_q + 14'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= 16'd0;
      index_q <= 14'd0;
      wt_q    <= 5'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      index_q <= index_d;
      wt_q    <= wt_d;
      err_q   <= err_d;
    end
  end

  // err can only be raised from IDLE and done only exists in DONE, so the
  // two pulses are mutually exclusive by construction.
  assign out_valid = (state_q == S_EMIT);
  assign busy      = (state_q == S_EMIT);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign word      = word_q;
  assign index     = index_q;

endmodule

// File: tb/tb_weight_word_gen.sv
// Testbench for weight_word_gen: scoreboard of expected (word, index) pairs
// filled by the stimulus side, drained by a negedge monitor on each transfer.
module tb_weight_word_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  weight = 5'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] word;
  logic [13:0] index;
  logic        busy;
  logic        done;
  logic        err;

  weight_word_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .weight   (weight),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .word     (word),
    .index    (index),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    logic [13:0] i;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int xfer_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int last_xfer_cyc = 0;
  logic [15:0] first_w [4];
  logic [15:0] last_w = 16'd0;
  logic [13:0] last_i = 14'd0;
  logic [15:0] prev_xfer_w = 16'd0;
  logic        hold_prev = 1'b0;
  logic [15:0] hold_w = 16'd0;
  logic [13:0] hold_i = 14'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: brute-force enumeration of all 16-bit values by popcount.
  task automatic fill_sb(input int w);
    int idx;
    idx = 0;
    sb.delete();
    for (int v = 0; v < 65536; v++) begin
      if ($countones(16'(v)) == w) begin
        sb.push_back('{w: 16'(v), i: 14'(idx)});
        idx++;
      end
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (done || err) chk("done_err_excl", 32'(done & err), 32'd0);
    if (hold_prev && out_valid) begin
      chk("stall_word_stable", 32'(word), 32'(hold_w));
      chk("stall_index_stable", 32'(index), 32'(hold_i));
    end
    hold_prev = out_valid && !out_ready;
    hold_w    = word;
    hold_i    = index;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got word %0h index %0d, expected no transfer", word, index);
      end else begin
        e = sb.pop_front();
        chk("xfer_word", 32'(word), 32'(e.w));
        chk("xfer_index", 32'(index), 32'(e.i));
      end
      if (xfer_cnt > 0) chk("ascending", 32'(word > prev_xfer_w), 32'd1);
      if (xfer_cnt < 4) first_w[xfer_cnt] = word;
      last_w        = word;
      last_i        = index;
      prev_xfer_w   = word;
      last_xfer_cyc = cyc;
      xfer_cnt++;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last", 32'(cyc), 32'(last_xfer_cyc + 1));
    end
    if (err) err_cnt++;
  end

  // mode 0: out_ready=1; mode 1: random out_ready; mode 2: out_ready=1 with
  // start held high and weight changing throughout EMIT.
  // Called just after a rising edge with the block in IDLE.
  task automatic run_seq(input int w, input int n_exp, input int mode);
    int c;
    c = 0;
    fill_sb(w);
    xfer_cnt = 0;
    done_cnt = 0;
    out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    start  = 1'b1;
    weight = 5'(w);
    @(posedge clk); #1;
    chk("valid_after_start", 32'(out_valid), 32'd1);
    chk("busy_in_emit", 32'(busy), 32'd1);
    chk("first_index", 32'(index), 32'd0);
    if (mode != 2) start = 1'b0;
    while (done_cnt == 0 && c < 40000) begin
      if (mode == 1) out_ready = 1'($urandom_range(0, 1));
      if (mode == 2) weight = 5'($urandom_range(0, 31));
      @(posedge clk); #1;
      c++;
    end
    start = 1'b0;
    chk("done_pulses", 32'(done_cnt), 32'd1);
    chk("xfer_count", 32'(xfer_cnt), 32'(n_exp));
    chk("sb_drained", 32'(sb.size()), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("done_single", 32'(done_cnt), 32'd1);
    chk("idle_valid_low", 32'(out_valid), 32'd0);
    chk("idle_busy_low", 32'(busy), 32'd0);
    chk("no_extra_xfer", 32'(xfer_cnt), 32'(n_exp));
  endtask

  task automatic chk_reset_vals();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_word", 32'(word), 32'd0);
    chk("rst_index", 32'(index), 32'd0);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();

    // Start on the very cycle reset is released.
    rst = 1'b0;
    run_seq(2, 120, 0);
    chk("w2_word0", 32'(first_w[0]), 32'h0003);
    chk("w2_word1", 32'(first_w[1]), 32'h0005);
    chk("w2_word2", 32'(first_w[2]), 32'h0006);
    chk("w2_word3", 32'(first_w[3]), 32'h0009);
    chk("w2_last_word", 32'(last_w), 32'hC000);
    chk("w2_last_index", 32'(last_i), 32'd119);

    run_seq(0, 1, 0);
    chk("w0_word", 32'(last_w), 32'h0000);
    chk("w0_index", 32'(last_i), 32'd0);

    run_seq(16, 1, 0);
    chk("w16_word", 32'(last_w), 32'hFFFF);
    chk("w16_index", 32'(last_i), 32'd0);

    // Out-of-range weight.
    err_cnt = 0;
    xfer_cnt = 0;
    start  = 1'b1;
    weight = 5'd17;
    @(posedge clk); #1;
    start = 1'b0;
    chk("w17_err_pulse", 32'(err), 32'd1);
    chk("w17_valid_low", 32'(out_valid), 32'd0);
    chk("w17_busy_low", 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk("w17_err_cleared", 32'(err), 32'd0);
    chk("w17_still_idle", 32'(out_valid), 32'd0);
    chk("w17_err_count", 32'(err_cnt), 32'd1);
    chk("w17_no_xfer", 32'(xfer_cnt), 32'd0);

    run_seq(1, 16, 0);
    chk("w1_word0", 32'(first_w[0]), 32'h0001);
    chk("w1_word1", 32'(first_w[1]), 32'h0002);
    chk("w1_last_word", 32'(last_w), 32'h8000);
    chk("w1_last_index", 32'(last_i), 32'd15);

    run_seq(3, 560, 1);
    chk("w3_word0", 32'(first_w[0]), 32'h0007);
    chk("w3_last_word", 32'(last_w), 32'hE000);
    chk("w3_last_index", 32'(last_i), 32'd559);

    // Abort a weight-8 sequence mid-stream.
    fill_sb(8);
    xfer_cnt = 0;
    done_cnt = 0;
    out_ready = 1'b1;
    start  = 1'b1;
    weight = 5'd8;
    @(posedge clk); #1;
    start = 1'b0;
    c = 0;
    while (index != 14'd100 && c < 500) begin
      @(posedge clk); #1;
      c++;
    end
    chk("abort_reached_idx100", 32'(index), 32'd100);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals();
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    rst = 1'b0;

    run_seq(8, 12870, 2);
    chk("w8_word0", 32'(first_w[0]), 32'h00FF);
    chk("w8_word1", 32'(first_w[1]), 32'h017F);
    chk("w8_last_word", 32'(last_w), 32'hFF00);
    chk("w8_last_index", 32'(last_i), 32'd12869);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
